store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: queues aligned stores and drains them one at a time to a write bus.
// Optional STORE_CONFLICT_EN adds a combinational load-address conflict check.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [1:0]            st_size,
  input  logic [31:0]           st_addr,
  input  logic [DATA_W-1:0]     st_wdata,
  output logic                  st_excp,
  output logic [31:0]           st_badvaddr,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [31:0]           data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W/8-1:0]   data_wstrb,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
`ifdef STORE_CONFLICT_EN
  input  logic [31:0]           ld_addr,
  output logic                  ld_conflict,
`endif
  output logic                  empty
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  logic [31:0]       addr_mem [DEPTH];
  logic [1:0]        size_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [STRB_W-1:0] strb_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  state_t            state, state_nxt;

  logic              full, fire, misaligned, push, pop;
  logic [OFF-1:0]    lane;
  logic [STRB_W-1:0] base_mask;

  assign full     = (count == CNT_W'(DEPTH));
  assign st_ready = !full;
  assign fire     = st_valid && st_ready;
  assign lane     = st_addr[OFF-1:0];

  // A dword store is never legal on a 32-bit bus, whatever its address.
  always_comb begin
    misaligned = 1'b0;
    base_mask  = STRB_W'(1);
    case (st_size)
      2'b00: begin
        misaligned = 1'b0;
        base_mask  = STRB_W'(1);
      end
      2'b01: begin
        misaligned = st_addr[0];
        base_mask  = STRB_W'(3);
      end
      2'b10: begin
        misaligned = |st_addr[1:0];
        base_mask  = STRB_W'(4'hF);
      end
      default: begin
        misaligned = (DATA_W == 32) || (|st_addr[2:0]);
        base_mask  = STRB_W'(8'hFF);
      end
    endcase
  end

  assign push = fire && !misaligned;
  assign pop  = (state == S_WAIT) && data_data_ok;

  // NOTE: every variable driven in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_W'(1);
    else if (!push && pop)
      count_nxt = count - CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count_nxt != '0) state_nxt = S_REQ;
      S_REQ:   if (data_addr_ok) state_nxt = S_WAIT;
      S_WAIT:  if (data_data_ok) state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the entry storage has no reset; count and pointers decide which
  // entries are meaningful, so clearing the array on reset buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= st_addr;
      size_mem[wr_ptr] <= st_size;
      data_mem[wr_ptr] <= st_wdata << {lane, 3'b000};
      strb_mem[wr_ptr] <= base_mask << lane;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= S_IDLE;
      st_excp     <= 1'b0;
      st_badvaddr <= '0;
    end else begin
      count   <= count_nxt;
      state   <= state_nxt;
      st_excp <= fire && misaligned;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fire && misaligned) st_badvaddr <= st_addr;
    end
  end

  // The head only moves on pop (in WAIT), so the request fields are stable
  // from the start of REQ through the address handshake.
  assign data_req   = (state == S_REQ);
  assign data_wr    = 1'b1;
  assign data_addr  = addr_mem[rd_ptr];
  assign data_size  = size_mem[rd_ptr];
  assign data_wdata = data_mem[rd_ptr];
  assign data_wstrb = strb_mem[rd_ptr];
  assign empty      = (count == '0) && (state == S_IDLE);

`ifdef STORE_CONFLICT_EN
  // The in-flight head is still counted, so it also participates in the match.
  localparam logic [31:0] LINE_MASK = ~32'(STRB_W - 1);
  logic [PTR_W-1:0] dist;

  always_comb begin
    ld_conflict = 1'b0;
    dist        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dist = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(dist) < count) && (((addr_mem[i] ^ ld_addr) & LINE_MASK) == '0))
        ld_conflict = 1'b1;
    end
  end
`endif

endmodule
